// File: rtl/o_writeback.sv
// Output write-back stage: buffers PE output vectors in a small FIFO and writes them
// to consecutive SRAM rows from a per-pass base, pulsing done when the pass is committed.
module o_writeback #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 10,
   parameter int ROWS_W     = 10,
   parameter int VEC_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ROWS_W-1:0] num_rows,
   input  logic              o_vld_in,
   output logic              o_rdy_out,
   input  logic [VEC_W-1:0]  o_vec_in,
   input  logic              sram_wr_rdy,
   output logic              sram_wr_en,
   output logic [ADDR_W-1:0] sram_wr_addr,
   output logic [VEC_W-1:0]  sram_wr_data,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [VEC_W-1:0]  mem_q [FIFO_DEPTH];
   logic [VEC_W-1:0]  mem_d [FIFO_DEPTH];
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ROWS_W-1:0] rows_q, rows_d;
   logic [ROWS_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [ROWS_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
   logic [VEC_W-1:0]  hold_data_q, hold_data_d;

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              head_valid;
   logic [ADDR_W-1:0] cur_addr;
   logic [VEC_W-1:0]  head_data;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign cur_addr   = base_q + ADDR_W'(wr_cnt_q);
   assign head_data  = mem_q[rd_ptr_q[IDX_W-1:0]];

   // When no head is presented, address/data hold the last committed write so they stay stable.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_d       = mem_q;
      base_d      = base_q;
      rows_d      = rows_q;
      acc_cnt_d   = acc_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;

      o_rdy_out    = (state_q == RUN) && !fifo_full && (acc_cnt_q < rows_q);
      sram_wr_en   = (state_q == RUN) && !fifo_empty && sram_wr_rdy;
      push         = o_vld_in && o_rdy_out;
      pop          = sram_wr_en;
      head_valid   = (state_q == RUN) && !fifo_empty;
      sram_wr_addr = head_valid ? cur_addr : hold_addr_q;
      sram_wr_data = head_valid ? head_data : hold_data_q;
      busy         = (state_q == RUN);
      done         = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d    = base_addr;
               rows_d    = num_rows;
               acc_cnt_d = '0;
               wr_cnt_d  = '0;
               state_d   = (num_rows != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (push) begin
               mem_d[wr_ptr_q[IDX_W-1:0]] = o_vec_in;
               wr_ptr_d  = wr_ptr_q + PTR_W'(1);
               acc_cnt_d = acc_cnt_q + ROWS_W'(1);
            end
            if (pop) begin
               rd_ptr_d    = rd_ptr_q + PTR_W'(1);
               wr_cnt_d    = wr_cnt_q + ROWS_W'(1);
               hold_addr_d = cur_addr;
               hold_data_d = head_data;
               if (wr_cnt_q == rows_q - ROWS_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         base_q      <= '0;
         rows_q      <= '0;
         acc_cnt_q   <= '0;
         wr_cnt_q    <= '0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         base_q      <= base_d;
         rows_q      <= rows_d;
         acc_cnt_q   <= acc_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         mem_q       <= mem_d;
      end
   end

endmodule

// File: tb/tb_o_writeback.sv
// Testbench for o_writeback: a queue-based model of a write-back pass checked every cycle,
// plus hand-computed expectations for the directed passes.
module tb_o_writeback;

   localparam int DEPTH = 4;
   localparam int AW    = 10;
   localparam int RW    = 10;
   localparam int VW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [RW-1:0] num_rows = '0;
   logic          o_vld_in = 1'b0;
   logic [VW-1:0] o_vec_in = '0;
   logic          sram_wr_rdy = 1'b0;
   logic          o_rdy_out;
   logic          sram_wr_en;
   logic [AW-1:0] sram_wr_addr;
   logic [VW-1:0] sram_wr_data;
   logic          busy;
   logic          done;

   o_writeback #(
      .FIFO_DEPTH(DEPTH),
      .ADDR_W(AW),
      .ROWS_W(RW),
      .VEC_W(VW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(base_addr),
      .num_rows(num_rows),
      .o_vld_in(o_vld_in),
      .o_rdy_out(o_rdy_out),
      .o_vec_in(o_vec_in),
      .sram_wr_rdy(sram_wr_rdy),
      .sram_wr_en(sram_wr_en),
      .sram_wr_addr(sram_wr_addr),
      .sram_wr_data(sram_wr_data),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   // Abstract pass model: 0=idle, 1=running, 2=done cycle
   int            m_phase = 0;
   logic [VW-1:0] m_q[$];
   int            m_acc = 0;
   int            m_wr = 0;
   int            m_base = 0;
   int            m_rows = 0;

   bit            acc_flag = 1'b0;
   int            done_cnt = 0;
   int            done_cyc = -1;
   int            log_addr[$];
   logic [VW-1:0] log_data[$];
   int            log_cyc[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs and the model step on the falling edge.
   task automatic applyStimulus(input logic s, input int b, input int r, input logic v,
                                input logic [VW-1:0] d, input logic w);
      start       = s;
      base_addr   = AW'(b);
      num_rows    = RW'(r);
      o_vld_in    = v;
      o_vec_in    = d;
      sram_wr_rdy = w;
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      logic          e_rdy;
      logic          e_wen;
      logic [AW-1:0] e_addr;
      logic [VW-1:0] e_data;
      cyc++;
      e_rdy  = (m_phase == 1) && (m_q.size() < DEPTH) && (m_acc < m_rows);
      e_wen  = (m_phase == 1) && (m_q.size() > 0) && sram_wr_rdy;
      e_addr = AW'(m_base + m_wr);
      e_data = (m_q.size() > 0) ? m_q[0] : '0;
      if (check_en) begin
         checkOutput("o_rdy_out", 32'(o_rdy_out), 32'(e_rdy));
         checkOutput("sram_wr_en", 32'(sram_wr_en), 32'(e_wen));
         checkOutput("busy", 32'(busy), 32'(m_phase == 1));
         checkOutput("done", 32'(done), 32'(m_phase == 2));
         if (e_wen) begin
            checkOutput("sram_wr_addr", 32'(sram_wr_addr), 32'(e_addr));
            checkOutput("sram_wr_data", sram_wr_data, e_data);
         end
      end
      acc_flag = o_vld_in && o_rdy_out;
      if (sram_wr_en) begin
         log_addr.push_back(int'(sram_wr_addr));
         log_data.push_back(sram_wr_data);
         log_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!rst) begin
         m_phase = 0;
         m_q.delete();
         m_acc = 0;
         m_wr = 0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_base  = int'(base_addr);
               m_rows  = int'(num_rows);
               m_acc   = 0;
               m_wr    = 0;
               m_phase = (m_rows != 0) ? 1 : 2;
            end
            1: begin
               if (e_wen) begin
                  void'(m_q.pop_front());
                  m_wr++;
                  if (m_wr == m_rows) m_phase = 2;
               end
               if (e_rdy && o_vld_in) begin
                  m_q.push_back(o_vec_in);
                  m_acc++;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   int start_cyc = 0;
   int pass_acc = 0;

   task automatic runPass(input int base, input int rows, input logic [VW-1:0] seed,
                          input int vld_pct, input int wr_pct, input int hold, input bit pulse_start);
      int   sent;
      int   k;
      int   d0;
      logic v;
      logic w;
      sent = 0;
      k = 0;
      d0 = done_cnt;
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
      applyStimulus(1'b1, base, rows, 1'b0, '0, 1'b1);
      start_cyc = cyc;
      while (done_cnt == d0 && k < 600) begin
         v = ($urandom_range(99) < vld_pct);
         w = (k >= hold) && ($urandom_range(99) < wr_pct);
         applyStimulus(pulse_start && (k == 1), (k * 37) & 1023, (k + 9) & 1023, v, seed + VW'(sent), w);
         if (acc_flag) sent++;
         k++;
         if (hold > 0 && k == hold) begin
            checkOutput("bp_accepted", 32'(sent), 32'(DEPTH));
            checkOutput("bp_rdy_low", 32'(o_rdy_out), 32'd0);
         end
      end
      checkOutput("pass_done_pulses", 32'(done_cnt - d0), 32'd1);
      pass_acc = sent;
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 1'b0);
   endtask

   int last_cyc;

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 1'b0);
      check_en = 1'b1;
      rst = 1'b1;
      checkOutput("reset_rdy", 32'(o_rdy_out), 32'd0);
      checkOutput("reset_wen", 32'(sram_wr_en), 32'd0);
      checkOutput("reset_addr", 32'(sram_wr_addr), 32'd0);
      checkOutput("reset_data", sram_wr_data, 32'd0);

      // Basic pass: four back-to-back vectors
      runPass(16, 4, 32'hA000_0000, 100, 100, 0, 1'b0);
      checkOutput("t2_count", 32'(log_addr.size()), 32'd4);
      foreach (log_addr[i]) begin
         checkOutput("t2_addr", 32'(log_addr[i]), 32'(16 + i));
         checkOutput("t2_data", log_data[i], 32'hA000_0000 + 32'(i));
         checkOutput("t2_cycle", 32'(log_cyc[i]), 32'(start_cyc + 2 + i));
      end
      last_cyc = (log_cyc.size() > 0) ? log_cyc[$] : -100;
      checkOutput("t2_done_cycle", 32'(done_cyc), 32'(last_cyc + 1));

      // Backpressure: SRAM stalls for 10 cycles
      runPass(128, 8, 32'hB000_0000, 100, 100, 10, 1'b0);
      checkOutput("t3_count", 32'(log_addr.size()), 32'd8);
      foreach (log_data[i]) begin
         checkOutput("t3_data", log_data[i], 32'hB000_0000 + 32'(i));
      end

      // Address wrap
      runPass(1022, 4, 32'hC000_0000, 100, 100, 0, 1'b0);
      checkOutput("t4_count", 32'(log_addr.size()), 32'd4);
      foreach (log_addr[i]) begin
         checkOutput("t4_addr", 32'(log_addr[i]), 32'((1022 + i) % 1024));
      end

      // Zero rows, then a start pulsed mid-pass
      runPass(5, 0, 32'hD000_0000, 100, 100, 0, 1'b0);
      checkOutput("t5_no_writes", 32'(log_addr.size()), 32'd0);
      checkOutput("t5_done_cycle", 32'(done_cyc), 32'(start_cyc + 1));
      runPass(256, 3, 32'hD100_0000, 100, 100, 0, 1'b1);
      checkOutput("t5_ign_count", 32'(log_addr.size()), 32'd3);
      foreach (log_addr[i]) begin
         checkOutput("t5_ign_addr", 32'(log_addr[i]), 32'(256 + i));
      end

      // Reset in the middle of a pass with three entries queued
      applyStimulus(1'b1, 80, 8, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 0, 0, 1'b1, 32'hE000_0000 + 32'(i), 1'b0);
      end
      rst = 1'b0;
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 1'b1);
      rst = 1'b1;
      checkOutput("t1_rdy", 32'(o_rdy_out), 32'd0);
      checkOutput("t1_wen", 32'(sram_wr_en), 32'd0);
      checkOutput("t1_done", 32'(done), 32'd0);
      checkOutput("t1_busy", 32'(busy), 32'd0);
      runPass(96, 2, 32'hE100_0000, 100, 100, 0, 1'b0);
      checkOutput("t1_count", 32'(log_addr.size()), 32'd2);
      foreach (log_addr[i]) begin
         checkOutput("t1_addr", 32'(log_addr[i]), 32'(96 + i));
      end

      // Random valid/ready traffic
      runPass(500, 37, 32'hF000_0000, 60, 50, 0, 1'b0);
      checkOutput("t6_count", 32'(log_addr.size()), 32'd37);
      checkOutput("t6_accepted", 32'(pass_acc), 32'd37);
      foreach (log_addr[i]) begin
         checkOutput("t6_addr", 32'(log_addr[i]), 32'(500 + i));
         checkOutput("t6_data", log_data[i], 32'hF000_0000 + 32'(i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
